// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module     : mux_pkg
// Description: Shared constants and helpers for the mux_tree_pipe stream
//              multiplexer.
//              MODE_FIXED / MODE_RR : values of the mode input.
//              chan_count(bits)     : number of channels for a select width.
// Revision   : 1.0  initial release
// ============================================================================
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int chan_count(input int bits);
    return 1 << bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_tree.sv
`default_nettype none
// ============================================================================
// Module     : mux_tree
// Description: Combinational N:1 multiplexer of DATAWIDTH-bit words built as
//              BITS layers of 2:1 selects (N = 1 << BITS).
// Ports      : sel      [BITS-1:0]        channel index
//              in_data  [N*DATAWIDTH-1:0] flat channel words, channel i at
//                                         [i*DATAWIDTH +: DATAWIDTH]
//              out_data [DATAWIDTH-1:0]   selected word
// Revision   : 1.0  initial release
// ============================================================================
module mux_tree
  import mux_pkg::*;
#(
  parameter int BITS      = 2,
  parameter int DATAWIDTH = 8,
  localparam int N        = chan_count(BITS)
) (
  input  logic [BITS-1:0]        sel,
  input  logic [N*DATAWIDTH-1:0] in_data,
  output logic [DATAWIDTH-1:0]   out_data
);

  // Heap-ordered node array: node 0 is the root, nodes N-1 .. 2N-2 are the
  // leaves (channel i at index N-1+i). A node at depth d picks between its
  // two children using select bit BITS-1-d, so the MSB steers the root.
  logic [DATAWIDTH-1:0] nodes [0:2*N-2];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign nodes[N-1+i] = in_data[i*DATAWIDTH +: DATAWIDTH];
  end

  for (genvar d = 0; d < BITS; d++) begin : g_level
    for (genvar p = 0; p < (1 << d); p++) begin : g_node
      assign nodes[(1 << d) - 1 + p] = sel[BITS-1-d]
                                     ? nodes[(1 << (d + 1)) - 1 + 2*p + 1]
                                     : nodes[(1 << (d + 1)) - 1 + 2*p];
    end
  end

  assign out_data = nodes[0];

endmodule
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module     : mux_tree_pipe
// Description: N-channel valid/ready stream multiplexer with a single
//              registered output stage. Fixed-select or round-robin grant.
// Ports      : clk, rst_n (async, active-low)
//              mode      0 = fixed select, 1 = round-robin
//              select    channel used in fixed mode
//              in_data   flat channel data, in_valid / in_ready per channel
//              out_data, out_chan, out_valid (registered), out_ready
// Revision   : 1.0  initial release
// ============================================================================
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int BITS      = 2,
  parameter int DATAWIDTH = 8,
  localparam int N        = chan_count(BITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [BITS-1:0]        select,
  input  logic [N*DATAWIDTH-1:0] in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [DATAWIDTH-1:0]   out_data,
  output logic [BITS-1:0]        out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [BITS-1:0]      ptr;
  logic [BITS-1:0]      grant;
  logic [BITS-1:0]      cand;
  logic                 grant_valid;
  logic                 take;
  logic                 transfer;
  logic [DATAWIDTH-1:0] mux_data;

  assign take = !out_valid || out_ready;

  // Grant selection. In round-robin the search starts just after ptr and
  // wraps; the last candidate (k = N) is ptr itself.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    if (mode == MODE_FIXED) begin
      grant       = select;
      grant_valid = in_valid[select];
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = ptr + BITS'(k);
        if (!grant_valid && in_valid[cand]) begin
          grant       = cand;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_valid) in_ready[grant] = take;
  end

  // A grant always implies in_valid on that channel, so a transfer is just
  // a grant while the output register can accept.
  assign transfer = grant_valid && take;

  mux_tree #(
    .BITS      (BITS),
    .DATAWIDTH (DATAWIDTH)
  ) u_mux_tree (
    .sel      (grant),
    .in_data  (in_data),
    .out_data (mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '1;  // N-1: channel 0 wins the first round-robin search
    end else begin
      out_valid <= transfer || (out_valid && !out_ready);
      if (transfer) begin
        out_data <= mux_data;
        out_chan <= grant;
        if (mode == MODE_RR) ptr <= grant;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module     : tb_mux_tree_pipe
// Description: Self-checking bench for mux_tree_pipe (BITS=2, DATAWIDTH=8).
//              Channel i carries base+i so the source of every word is
//              visible in out_data.
// Revision   : 1.0  initial release
// ============================================================================
module tb_mux_tree_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  select;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_tree_pipe #(
    .BITS      (2),
    .DATAWIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ready;
    logic [7:0] base;
    logic [3:0] exp_ir;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_chan;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] base);
    in_data = {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endtask

  initial begin
    // mode, sel, valid, ready, base, exp in_ready, exp out_valid/data/chan
    tbl[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 8'hA0, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tbl[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 8'hB0, 4'b0100, 1'b1, 8'hB2, 2'd2};
    tbl[2]  = '{1'b0, 2'd1, 4'hD, 1'b1, 8'hB0, 4'b0000, 1'b0, 8'hB2, 2'd2};
    tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 8'hC0, 4'b0001, 1'b1, 8'hC0, 2'd0};
    tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 8'hD0, 4'b0010, 1'b1, 8'hD1, 2'd1};
    tbl[5]  = '{1'b1, 2'd0, 4'hA, 1'b1, 8'hE0, 4'b1000, 1'b1, 8'hE3, 2'd3};
    tbl[6]  = '{1'b1, 2'd0, 4'hA, 1'b1, 8'hF0, 4'b0010, 1'b1, 8'hF1, 2'd1};
    tbl[7]  = '{1'b1, 2'd0, 4'hA, 1'b1, 8'h10, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[8]  = '{1'b1, 2'd0, 4'hF, 1'b0, 8'h20, 4'b0000, 1'b1, 8'h13, 2'd3};
    tbl[9]  = '{1'b1, 2'd0, 4'hF, 1'b0, 8'h20, 4'b0000, 1'b1, 8'h13, 2'd3};
    tbl[10] = '{1'b1, 2'd0, 4'hF, 1'b1, 8'h30, 4'b0001, 1'b1, 8'h30, 2'd0};
    tbl[11] = '{1'b1, 2'd0, 4'h0, 1'b1, 8'h30, 4'b0000, 1'b0, 8'h30, 2'd0};
    tbl[12] = '{1'b1, 2'd0, 4'h1, 1'b0, 8'h40, 4'b0001, 1'b1, 8'h40, 2'd0};
    tbl[13] = '{1'b0, 2'd0, 4'hF, 1'b0, 8'h50, 4'b0000, 1'b1, 8'h40, 2'd0};
    tbl[14] = '{1'b0, 2'd0, 4'hF, 1'b1, 8'h60, 4'b0001, 1'b1, 8'h60, 2'd0};
    tbl[15] = '{1'b0, 2'd2, 4'hF, 1'b1, 8'h70, 4'b0100, 1'b1, 8'h72, 2'd2};
    tbl[16] = '{1'b1, 2'd0, 4'hF, 1'b1, 8'h80, 4'b0010, 1'b1, 8'h81, 2'd1};

    rst_n     = 1'b0;
    mode      = 1'b0;
    select    = 2'd0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data",  {24'd0, out_data},  32'd0);
    check("reset_out_chan",  {30'd0, out_chan},  32'd0);
    check("reset_in_ready",  {28'd0, in_ready},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      mode      = tbl[i].mode;
      select    = tbl[i].sel;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ready;
      set_data(tbl[i].base);
      #1;
      check($sformatf("vec%0d_in_ready", i), {28'd0, in_ready}, {28'd0, tbl[i].exp_ir});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
      check($sformatf("vec%0d_out_data", i),  {24'd0, out_data},  {24'd0, tbl[i].exp_data});
      check($sformatf("vec%0d_out_chan", i),  {30'd0, out_chan},  {30'd0, tbl[i].exp_chan});
    end

    // Asynchronous reset between clock edges while holding a word.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_out_data",  {24'd0, out_data},  32'd0);
    check("async_rst_out_chan",  {30'd0, out_chan},  32'd0);

    // Round-robin from reset, all valid: 0,1,2,3,0,... at one word per cycle.
    @(negedge clk);
    rst_n     = 1'b1;
    mode      = 1'b1;
    select    = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data(8'h90);
    for (int k = 0; k < 8; k++) begin
      logic [1:0] ec;
      ec = 2'(k % 4);
      #1;
      check($sformatf("rr%0d_in_ready", k), {28'd0, in_ready}, {28'd0, 4'b0001 << ec});
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("rr%0d_out_chan", k),  {30'd0, out_chan},  {30'd0, ec});
      check($sformatf("rr%0d_out_data", k),  {24'd0, out_data},  {24'd0, 8'h90 + {6'd0, ec}});
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
